// File: rtl/fir_stream_driver_if.sv
// Host/stream/FIR-side signal bundle for fir_stream_driver.
// master = host + FIR model side, slave = the driver itself.
interface fir_stream_driver_if #(
    parameter int unsigned TAP_SIZE = 3,
    parameter int unsigned X_N_SIZE = 8,
    parameter int unsigned Y_N_SIZE = 11
) ();
    logic                coef_we;
    logic [1:0]          coef_addr;
    logic [TAP_SIZE-1:0] coef_data;
    logic                cfg_start;
    logic                s_valid;
    logic [X_N_SIZE-1:0] s_data;
    logic                s_ready;
    logic [X_N_SIZE-1:0] fir_x_n;
    logic                fir_tvalid;
    logic                fir_set_coeffs;
    logic [Y_N_SIZE-1:0] fir_y_n;
    logic                m_valid;
    logic [Y_N_SIZE-1:0] m_y_n;
    logic                underrun;
    logic                busy;

    modport master (
        output coef_we, coef_addr, coef_data, cfg_start, s_valid, s_data, fir_y_n,
        input  s_ready, fir_x_n, fir_tvalid, fir_set_coeffs, m_valid, m_y_n, underrun, busy
    );

    modport slave (
        input  coef_we, coef_addr, coef_data, cfg_start, s_valid, s_data, fir_y_n,
        output s_ready, fir_x_n, fir_tvalid, fir_set_coeffs, m_valid, m_y_n, underrun, busy
    );
endinterface

// File: rtl/fir_stream_driver.sv
// Upstream driver for a serial-MAC FIR: coefficient bank + serial load, sample FIFO, result capture.
// Optional `FIR_DRV_UNDERRUN_STOP_EN: leave STREAM on underrun instead of inserting zero samples.
module fir_stream_driver #(
    parameter int unsigned TAP_SIZE      = 3,
    parameter int unsigned NBR_OF_TAPS   = 3,
    parameter int unsigned X_N_SIZE      = 8,
    parameter int unsigned Y_N_SIZE      = 11,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SAMPLE_PERIOD = 6
) (
    input logic                i_clk,
    input logic                i_reset,
    fir_stream_driver_if.slave io_bus
);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_MAX = (SAMPLE_PERIOD > NBR_OF_TAPS) ? SAMPLE_PERIOD : NBR_OF_TAPS;
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLoad   = 2'd1;
    localparam logic [1:0] StGap    = 2'd2;
    localparam logic [1:0] StStream = 2'd3;

    logic [1:0]          r_state, w_state_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    logic [TAP_SIZE-1:0] r_bank [NBR_OF_TAPS];
    logic [TAP_SIZE-1:0] w_bank_d [NBR_OF_TAPS];
    logic [TAP_SIZE-1:0] r_snap [NBR_OF_TAPS];
    logic [X_N_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr, r_rptr;
    logic [PTR_W:0]      r_fill;
    logic [X_N_SIZE-1:0] r_x_n;
    logic                r_m_valid;
    logic [Y_N_SIZE-1:0] r_m_y_n;
    logic                r_underrun;
    logic                r_cfg_pend;
    logic                r_first;

    logic                w_full, w_empty, w_push, w_pop;
    logic                w_boundary, w_under, w_last, w_enter_load;
    logic [X_N_SIZE-1:0] w_sample;
    logic [TAP_SIZE-1:0] w_coef;

    assign w_full       = (r_fill == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty      = (r_fill == '0);
    assign w_push       = io_bus.s_valid && !w_full;
    assign w_boundary   = (r_state == StStream) && (r_cnt == '0);
    assign w_pop        = w_boundary && !w_empty;
    assign w_under      = w_boundary && w_empty;
    assign w_last       = (r_state == StStream) && (r_cnt == CNT_W'(SAMPLE_PERIOD - 1));
    assign w_sample     = w_pop ? r_mem[r_rptr] : '0;
    assign w_enter_load = (w_state_d == StLoad) && (r_state != StLoad);

    // Bank including this cycle's write, so a write alongside cfg_start lands in the snapshot.
    always_comb begin
        for (int i = 0; i < NBR_OF_TAPS; i++) begin
            w_bank_d[i] = r_bank[i];
            if (io_bus.coef_we && (io_bus.coef_addr == 2'(i))) begin
                w_bank_d[i] = io_bus.coef_data;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (io_bus.cfg_start) begin
                    w_state_d = StLoad;
                end else if (!w_empty) begin
                    w_state_d = StStream;
                end
            end
            StLoad: begin
                if (r_cnt == CNT_W'(NBR_OF_TAPS - 1)) begin
                    w_state_d = StGap;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StGap: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            default: begin
`ifdef FIR_DRV_UNDERRUN_STOP_EN
                if (w_under) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else
`endif
                if (w_last) begin
                    w_cnt_d = '0;
                    if (r_cfg_pend || io_bus.cfg_start) begin
                        w_state_d = StLoad;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
        endcase
    end

    // Coefficient for the current load slot: bank[N-1] goes out first.
    always_comb begin
        w_coef = '0;
        for (int i = 0; i < NBR_OF_TAPS; i++) begin
            if (r_cnt == CNT_W'(NBR_OF_TAPS - 1 - i)) begin
                w_coef = r_snap[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fill     <= '0;
            r_x_n      <= '0;
            r_m_valid  <= 1'b0;
            r_m_y_n    <= '0;
            r_underrun <= 1'b0;
            r_cfg_pend <= 1'b0;
            r_first    <= 1'b0;
            for (int i = 0; i < NBR_OF_TAPS; i++) begin
                r_bank[i] <= '0;
                r_snap[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            for (int i = 0; i < NBR_OF_TAPS; i++) begin
                r_bank[i] <= w_bank_d[i];
                if (w_enter_load) begin
                    r_snap[i] <= w_bank_d[i];
                end
            end

            if (w_push) begin
                r_mem[r_wptr] <= io_bus.s_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + 1'b1;
            end else if (!w_push && w_pop) begin
                r_fill <= r_fill - 1'b1;
            end

            if (w_boundary) begin
                r_x_n <= w_sample;
            end

            r_cfg_pend <= (r_state == StStream) && !w_last && (r_cfg_pend || io_bus.cfg_start);

            if ((r_state == StIdle) && (w_state_d == StStream)) begin
                r_first <= 1'b1;
            end else if (w_last) begin
                r_first <= 1'b0;
            end

            r_m_valid <= w_last && !r_first;
            if (w_last && !r_first) begin
                r_m_y_n <= io_bus.fir_y_n;
            end

            if (w_under) begin
                r_underrun <= 1'b1;
            end else if (io_bus.cfg_start) begin
                r_underrun <= 1'b0;
            end
        end
    end

    always_comb begin
        io_bus.fir_x_n = '0;
        if (r_state == StLoad) begin
            io_bus.fir_x_n = {{(X_N_SIZE - TAP_SIZE){w_coef[TAP_SIZE-1]}}, w_coef};
        end else if (r_state == StStream) begin
            io_bus.fir_x_n = w_boundary ? w_sample : r_x_n;
        end
    end

`ifdef FIR_DRV_UNDERRUN_STOP_EN
    assign io_bus.fir_tvalid = (r_state == StStream) && !w_under;
`else
    assign io_bus.fir_tvalid = (r_state == StStream);
`endif
    assign io_bus.fir_set_coeffs = (r_state == StLoad);
    assign io_bus.s_ready        = !w_full;
    assign io_bus.m_valid        = r_m_valid;
    assign io_bus.m_y_n          = r_m_y_n;
    assign io_bus.underrun       = r_underrun;
    assign io_bus.busy           = (r_state != StIdle);
endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed bench for fir_stream_driver with a behavioural one-period-latency FIR model.
module tb_fir_stream_driver;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    fir_stream_driver_if #(.TAP_SIZE(3), .X_N_SIZE(8), .Y_N_SIZE(11)) bus ();

    fir_stream_driver dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [7:0] tap [3];
    logic signed [7:0] dl [3];
    logic [10:0]       fir_y;
    int                tb_cnt;
    logic [7:0]        x_q [$];
    logic [10:0]       y_q [$];
    logic [7:0]        last_x;
    int                hold_err;
    int                full_seen;

    assign bus.fir_y_n = fir_y;

    function automatic logic [10:0] fir_conv();
        int acc;
        acc = int'(tap[0]) * int'(dl[0]) + int'(tap[1]) * int'(dl[1])
            + int'(tap[2]) * int'(dl[2]);
        return 11'(acc);
    endfunction

    // FIR model: taps shift in during set_coeffs; each new sample yields the previous sample's result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                tap[i] <= '0;
                dl[i]  <= '0;
            end
            fir_y  <= '0;
            tb_cnt <= 0;
        end else begin
            if (bus.fir_set_coeffs) begin
                tap[0] <= bus.fir_x_n;
                tap[1] <= tap[0];
                tap[2] <= tap[1];
            end
            if (bus.fir_tvalid && tb_cnt == 0) begin
                fir_y <= fir_conv();
                dl[0] <= bus.fir_x_n;
                dl[1] <= dl[0];
                dl[2] <= dl[1];
            end
            if (bus.fir_tvalid) tb_cnt <= (tb_cnt == 5) ? 0 : tb_cnt + 1;
            else tb_cnt <= 0;
        end
    end

    initial begin
        hold_err  = 0;
        full_seen = 0;
        last_x    = '0;
    end

    always @(negedge clk) begin
        if (bus.fir_tvalid && tb_cnt == 0) x_q.push_back(bus.fir_x_n);
        if (bus.m_valid) y_q.push_back(bus.m_y_n);
        if (bus.fir_tvalid && tb_cnt != 0 && bus.fir_x_n != last_x) hold_err <= hold_err + 1;
        if (!bus.s_ready) full_seen <= full_seen + 1;
        last_x <= bus.fir_x_n;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        for (int i = 0; i < 40 && !bus.s_ready; i++) tick();
        check_val("push_ready", 32'(bus.s_ready), 32'd1);
        tick();
        bus.s_valid = 1'b0;
    endtask

    logic [10:0] y_exp [4];
    logic [7:0]  x_exp [4];
    logic [7:0]  d_exp [5];
    int          xb, yb, fb, nz;
    logic [7:0]  got_nz [$];

    initial begin
        y_exp = '{11'h7FD, 11'h002, 11'h003, 11'h000};
        x_exp = '{8'd1, 8'd0, 8'd0, 8'd0};
        d_exp = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
        rst_n = 1'b0;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
        bus.cfg_start = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
        repeat (2) tick();
        check_val("rst_s_ready", 32'(bus.s_ready), 32'd1);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_x_n", 32'(bus.fir_x_n), 32'd0);
        check_val("rst_set", 32'(bus.fir_set_coeffs), 32'd0);
        check_val("rst_tvalid", 32'(bus.fir_tvalid), 32'd0);
        check_val("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check_val("rst_underrun", 32'(bus.underrun), 32'd0);
        rst_n = 1'b1;
        tick();

        // Coefficient load; bank[2] written in the same cycle as cfg_start.
        bus.coef_we = 1'b1; bus.coef_addr = 2'd0; bus.coef_data = 3'b101;
        tick();
        bus.coef_addr = 2'd1; bus.coef_data = 3'b010;
        tick();
        bus.coef_addr = 2'd2; bus.coef_data = 3'b011; bus.cfg_start = 1'b1;
        tick();
        bus.coef_we = 1'b0; bus.cfg_start = 1'b0;
        check_val("load0_set", 32'(bus.fir_set_coeffs), 32'd1);
        check_val("load0_x", 32'(bus.fir_x_n), 32'h03);
        check_val("load0_busy", 32'(bus.busy), 32'd1);
        bus.coef_we = 1'b1; bus.coef_addr = 2'd0; bus.coef_data = 3'b001;
        tick();
        bus.coef_we = 1'b0;
        check_val("load1_x", 32'(bus.fir_x_n), 32'h02);
        tick();
        check_val("load2_x_snap", 32'(bus.fir_x_n), 32'hFD);
        bus.coef_we = 1'b1; bus.coef_addr = 2'd0; bus.coef_data = 3'b101;
        tick();
        bus.coef_we = 1'b0;
        check_val("gap0_set", 32'(bus.fir_set_coeffs), 32'd0);
        check_val("gap0_tvalid", 32'(bus.fir_tvalid), 32'd0);
        check_val("gap0_x", 32'(bus.fir_x_n), 32'd0);
        check_val("gap0_busy", 32'(bus.busy), 32'd1);
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        check_val("gap1_busy", 32'(bus.busy), 32'd1);
        tick();
        check_val("idle_busy", 32'(bus.busy), 32'd0);
        check_val("idle_set", 32'(bus.fir_set_coeffs), 32'd0);

        // Impulse response through the FIR model, then underrun.
        xb = x_q.size();
        yb = y_q.size();
        push(8'd1); push(8'd0); push(8'd0); push(8'd0);
        repeat (45) tick();
        for (int i = 0; i < 4; i++) check_val($sformatf("imp_x%0d", i), 32'(x_q[xb+i]), 32'(x_exp[i]));
`ifdef FIR_DRV_UNDERRUN_STOP_EN
        check_val("imp_ny", 32'(y_q.size() - yb), 32'd3);
        for (int i = 0; i < 3; i++) check_val($sformatf("imp_y%0d", i), 32'(y_q[yb+i]), 32'(y_exp[i]));
        check_val("und_tvalid", 32'(bus.fir_tvalid), 32'd0);
        check_val("und_busy", 32'(bus.busy), 32'd0);
`else
        check_val("imp_ny", 32'(y_q.size() - yb >= 4), 32'd1);
        for (int i = 0; i < 4; i++) check_val($sformatf("imp_y%0d", i), 32'(y_q[yb+i]), 32'(y_exp[i]));
        check_val("und_x_zero", 32'(x_q[xb+4]), 32'd0);
        check_val("und_tvalid", 32'(bus.fir_tvalid), 32'd1);
`endif
        check_val("und_flag", 32'(bus.underrun), 32'd1);

        // FIFO fill to full, then a reload requested mid-period.
        fb = full_seen;
        xb = x_q.size();
        for (int i = 0; i < 5; i++) push(d_exp[i]);
        check_val("fifo_full_seen", 32'(full_seen > fb), 32'd1);
        for (int i = 0; i < 20 && !(bus.fir_tvalid && tb_cnt == 2); i++) tick();
        check_val("cfg_at_cnt2", 32'(bus.fir_tvalid && tb_cnt == 2), 32'd1);
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        tick(); tick();
        check_val("cfg_cnt5_tvalid", 32'(bus.fir_tvalid), 32'd1);
        check_val("cfg_cnt5_set", 32'(bus.fir_set_coeffs), 32'd0);
        tick();
        check_val("cfg_load_tvalid", 32'(bus.fir_tvalid), 32'd0);
        check_val("cfg_load_set", 32'(bus.fir_set_coeffs), 32'd1);
        check_val("cfg_load_x", 32'(bus.fir_x_n), 32'h03);
        check_val("cfg_und_clr", 32'(bus.underrun), 32'd0);
        repeat (80) tick();
        for (int i = xb; i < x_q.size(); i++) if (x_q[i] != 8'd0) got_nz.push_back(x_q[i]);
        nz = got_nz.size();
        check_val("stream_count", 32'(nz), 32'd5);
        for (int i = 0; i < 5; i++) check_val($sformatf("stream_x%0d", i), 32'(got_nz[i]), 32'(d_exp[i]));

        // Reset in the middle of a load.
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        for (int i = 0; i < 20 && !bus.fir_set_coeffs; i++) tick();
        check_val("mid_load_set", 32'(bus.fir_set_coeffs), 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_set", 32'(bus.fir_set_coeffs), 32'd0);
        check_val("arst_x", 32'(bus.fir_x_n), 32'd0);
        check_val("arst_s_ready", 32'(bus.s_ready), 32'd1);
        check_val("arst_busy", 32'(bus.busy), 32'd0);
        check_val("arst_underrun", 32'(bus.underrun), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        check_val("bank0_set", 32'(bus.fir_set_coeffs), 32'd1);
        check_val("bank0_x2", 32'(bus.fir_x_n), 32'd0);
        tick();
        check_val("bank0_x1", 32'(bus.fir_x_n), 32'd0);
        tick();
        check_val("bank0_x0", 32'(bus.fir_x_n), 32'd0);
        repeat (3) tick();
        check_val("post_busy", 32'(bus.busy), 32'd0);
        check_val("post_tvalid", 32'(bus.fir_tvalid), 32'd0);
        check_val("x_hold", 32'(hold_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
